// File: rtl/fir_result_pkg.sv
// -----------------------------------------------------------------------------
// fir_result_pkg
//   Shared definitions for the FIR result-side handshake: the handshake state
//   encoding and the default widths/block length used by the interface, the
//   top level and the testbench.
// -----------------------------------------------------------------------------
package fir_result_pkg;

  // IDLE    : waiting for the core to raise modwait
  // BUSY    : core is computing a sample, errors are accumulated
  // CAPTURE : one-cycle slot whose exit edge latches fir_out
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    CAPTURE = 2'd2
  } result_state_t;

  localparam int RESULT_DATA_W    = 16;
  localparam int RESULT_CNT_W     = 10;
  localparam int RESULT_BLOCK_LEN = 1000;

endpackage : fir_result_pkg

// File: rtl/result_handshake_if.sv
// -----------------------------------------------------------------------------
// result_handshake_if
//   Bundles the core-facing inputs, the bus acknowledge/clear strobes and the
//   result outputs of result_handshake.
//
//   Signals (direction seen from the slave, i.e. the handshake block):
//     modwait       in   core busy flag
//     err           in   core error flag
//     fir_out       in   core filtered output            [DATA_W]
//     rd_ack        in   bus read of the result register (1-cycle pulse)
//     ovr_clr       in   clears overrun (1-cycle pulse)
//     result_data   out  held result                     [DATA_W]
//     result_valid  out  unread result present
//     result_err    out  error seen while computing the held result
//     overrun       out  sticky: a result was overwritten unread
//     sample_count  out  captured samples modulo block length [CNT_W]
//     one_k_samples out  one-cycle pulse after a block completes
//
//   Modports: master drives the inputs (core + bus side), slave is the
//   handshake block.
// -----------------------------------------------------------------------------
interface result_handshake_if
  import fir_result_pkg::*;
#(
  parameter int DATA_W = RESULT_DATA_W,
  parameter int CNT_W  = RESULT_CNT_W
);

  logic              modwait;
  logic              err;
  logic [DATA_W-1:0] fir_out;
  logic              rd_ack;
  logic              ovr_clr;

  logic [DATA_W-1:0] result_data;
  logic              result_valid;
  logic              result_err;
  logic              overrun;
  logic [CNT_W-1:0]  sample_count;
  logic              one_k_samples;

  modport master (
    output modwait, err, fir_out, rd_ack, ovr_clr,
    input  result_data, result_valid, result_err, overrun,
           sample_count, one_k_samples
  );

  modport slave (
    input  modwait, err, fir_out, rd_ack, ovr_clr,
    output result_data, result_valid, result_err, overrun,
           sample_count, one_k_samples
  );

endinterface : result_handshake_if

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
//   Enable-gated up counter that wraps to zero after reaching rollover_val.
//
//   Ports:
//     clk           in   system clock, rising edge
//     n_rst         in   asynchronous active-low reset
//     count_enable  in   advance the count on this edge
//     rollover_val  in   last value before wrapping to 0 [CNT_W]
//     count_out     out  registered count                [CNT_W]
//     rollover_flag out  high in the cycle whose edge performs the wrap
//                        (combinational strobe; the parent registers it)
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic [CNT_W-1:0] count_out,
  output logic             rollover_flag
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_rollover;

  assign w_at_rollover = (r_count == rollover_val);
  assign rollover_flag = count_enable & w_at_rollover;
  assign count_out     = r_count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= w_at_rollover ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule : flex_counter

// File: rtl/result_handshake.sv
// -----------------------------------------------------------------------------
// result_handshake
//   Result-side handshake for the FIR filter peripheral. Follows the core's
//   modwait busy flag through IDLE -> BUSY -> CAPTURE, latches fir_out on the
//   exit edge of CAPTURE and holds it with a sticky result_valid until the bus
//   acknowledges the read. Overwriting an unread result raises a sticky
//   overrun; the core error seen during a sample travels with that result.
//
//   Ports:
//     clk    in   system clock, rising edge
//     n_rst  in   asynchronous active-low reset
//     bus    slave modport of result_handshake_if (see that file)
//
//   Configuration:
//     RESULT_SAMPLE_COUNT_EN  defined   -> sample counter (flex_counter) and
//                                          the one_k_samples pulse are built;
//                             undefined -> sample_count and one_k_samples are
//                                          tied to 0, no counter logic.
//
//   BLOCK_LEN (counter build only) must not exceed 2**CNT_W.
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module result_handshake
  import fir_result_pkg::*;
#(
  parameter int DATA_W    = RESULT_DATA_W,
  parameter int CNT_W     = RESULT_CNT_W
`ifdef RESULT_SAMPLE_COUNT_EN
  ,
  // Only meaningful when the counter exists.
  parameter int BLOCK_LEN = RESULT_BLOCK_LEN
`endif
) (
  input logic               clk,
  input logic               n_rst,
  result_handshake_if.slave bus
);

  result_state_t     r_state;
  result_state_t     w_next_state;

  logic              w_start;        // IDLE sees modwait: a new sample begins
  logic              w_busy;         // accumulate core errors this cycle
  logic              w_capture;      // this edge latches the result
  logic              w_overrun_set;

  logic              r_err_seen;
  logic [DATA_W-1:0] r_result_data;
  logic              r_result_valid;
  logic              r_result_err;
  logic              r_overrun;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_busy       = 1'b0;
    w_capture    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.modwait) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        // A one-cycle modwait glitch still walks through BUSY -> CAPTURE.
        if (!bus.modwait) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        // modwait is deliberately ignored here; IDLE picks up the next sample.
        w_capture    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------------------
  // A read acknowledged on the capture edge consumes the old value, so only an
  // unacknowledged overwrite counts as an overrun.
  assign w_overrun_set = w_capture & r_result_valid & ~bus.rd_ack;

  // NOTE: the result register is reset even though it only carries data,
  // because the bus must read 0 out of reset rather than an unknown value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_err_seen     <= 1'b0;
      r_result_data  <= '0;
      r_result_valid <= 1'b0;
      r_result_err   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      // Error history is per sample: cleared on entering BUSY, then sticky.
      if (w_start) begin
        r_err_seen <= 1'b0;
      end else if (w_busy) begin
        r_err_seen <= r_err_seen | bus.err;
      end

      if (w_capture) begin
        r_result_data <= bus.fir_out;
        // Include an error raised during the CAPTURE cycle itself.
        r_result_err  <= r_err_seen | bus.err;
      end

      // Capture has priority over the read acknowledge.
      if (w_capture) begin
        r_result_valid <= 1'b1;
      end else if (bus.rd_ack) begin
        r_result_valid <= 1'b0;
      end

      // Set has priority over clear so a simultaneous overrun is never lost.
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (bus.ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.result_data  = r_result_data;
  assign bus.result_valid = r_result_valid;
  assign bus.result_err   = r_result_err;
  assign bus.overrun      = r_overrun;

  // ---------------------------------------------------------------------------
  // Optional sample counter
  // ---------------------------------------------------------------------------
`ifdef RESULT_SAMPLE_COUNT_EN
  logic [CNT_W-1:0] w_sample_count;
  logic             w_block_wrap;
  logic             r_one_k_samples;

  flex_counter #(
    .CNT_W (CNT_W)
  ) u_sample_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .count_enable  (w_capture),
    .rollover_val  (CNT_W'(BLOCK_LEN - 1)),
    .count_out     (w_sample_count),
    .rollover_flag (w_block_wrap)
  );

  // The wrap strobe is combinational inside the counter; registering it here
  // makes the pulse appear in the cycle right after the wrapping edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_one_k_samples <= 1'b0;
    end else begin
      r_one_k_samples <= w_block_wrap;
    end
  end

  assign bus.sample_count  = w_sample_count;
  assign bus.one_k_samples = r_one_k_samples;
`else
  assign bus.sample_count  = {CNT_W{1'b0}};
  assign bus.one_k_samples = 1'b0;
`endif

endmodule : result_handshake

// File: tb/tb_result_handshake.sv
// -----------------------------------------------------------------------------
// tb_result_handshake
//   Self-checking bench for result_handshake. Stimulus is organised as sample
//   transactions (busy length, error/ack/clear pulses per cycle, idle gap);
//   the reference model knows from the transaction which edge captures and
//   applies the result/valid/overrun/counter rules with plain arithmetic.
//   Expectations for the counter follow RESULT_SAMPLE_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_result_handshake;
  import fir_result_pkg::*;

  localparam int DATA_W    = RESULT_DATA_W;
  localparam int CNT_W     = RESULT_CNT_W;
  localparam int BLOCK_LEN = RESULT_BLOCK_LEN;
`ifdef RESULT_SAMPLE_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk;
  logic n_rst;

  result_handshake_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  result_handshake dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_err;
  logic              m_ovr;
  int                m_total;
  logic              m_onek;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count(input int total);
    return COUNT_EN ? 32'(total % BLOCK_LEN) : 32'd0;
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    m_total = 0;
    m_onek  = 1'b0;
  endtask

  task automatic check_all();
    check("result_data",   32'(bus.result_data),   32'(m_data));
    check("result_valid",  32'(bus.result_valid),  32'(m_valid));
    check("result_err",    32'(bus.result_err),    32'(m_err));
    check("overrun",       32'(bus.overrun),       32'(m_ovr));
    check("sample_count",  32'(bus.sample_count),  exp_count(m_total));
    check("one_k_samples", 32'(bus.one_k_samples), 32'(COUNT_EN & m_onek));
  endtask

  // One clock edge: drive inputs, let the edge happen, advance the model,
  // then compare #1 after the edge. 'cap' marks the edge the transaction
  // schedule says latches the result; 'cap_err' is the error that result owes.
  task automatic edge_step(input logic mw, input logic er, input logic ack,
                           input logic clr, input logic [DATA_W-1:0] fir,
                           input bit cap, input logic cap_err);
    logic ovr_set;
    bus.modwait = mw;
    bus.err     = er;
    bus.rd_ack  = ack;
    bus.ovr_clr = clr;
    bus.fir_out = fir;
    @(posedge clk);
    ovr_set = 1'b0;
    m_onek  = 1'b0;
    if (cap) begin
      ovr_set = m_valid & ~ack;
      m_data  = fir;
      m_err   = cap_err;
      m_valid = 1'b1;
      m_total++;
      m_onek  = (m_total % BLOCK_LEN) == 0;
    end else if (ack) begin
      m_valid = 1'b0;
    end
    if (ovr_set)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    #1;
    check_all();
  endtask

  task automatic idle_cycle(input logic ack, input logic clr);
    edge_step(1'b0, 1'b0, ack, clr, DATA_W'($urandom), 1'b0, 1'b0);
  endtask

  // One sample: edge 1 enters BUSY, modwait stays high through edge 'busy',
  // edge busy+1 sees it low (-> CAPTURE), edge busy+2 captures, then 'gap'
  // idle edges. Mask bit i applies to edge i. Errors count from edge 2
  // (first edge in BUSY) through the capture edge.
  task automatic run_sample(input logic [DATA_W-1:0] data, input int busy,
                            input logic [15:0] err_mask, input logic [15:0] ack_mask,
                            input logic [15:0] clr_mask, input int gap,
                            input logic mw_on_cap);
    int   c;
    int   len;
    logic cap_err;
    logic mw;
    logic [DATA_W-1:0] fir;
    c       = busy + 2;
    len     = c + gap;
    cap_err = 1'b0;
    for (int i = 2; i <= c; i++) cap_err |= err_mask[i];
    for (int i = 1; i <= len; i++) begin
      if (i <= busy)   mw = 1'b1;
      else if (i == c) mw = mw_on_cap;
      else             mw = 1'b0;
      fir = (i == busy + 1 || i == c) ? data : DATA_W'($urandom);
      edge_step(mw, err_mask[i], ack_mask[i], clr_mask[i], fir, (i == c), cap_err);
    end
  endtask

  initial begin
    logic [15:0] err_m, ack_m, clr_m;

    model_reset();
    n_rst       = 1'b0;
    bus.modwait = 1'b0;
    bus.err     = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.ovr_clr = 1'b0;
    bus.fir_out = '0;

    // Reset state
    #3;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Basic sample: 4 busy cycles, 0x1234, no error
    run_sample(16'h1234, 4, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    check("t1_valid", 32'(bus.result_valid), 32'd1);
    check("t1_data",  32'(bus.result_data),  32'h1234);
    check("t1_err",   32'(bus.result_err),   32'd0);
    check("t1_count", 32'(bus.sample_count), exp_count(1));
    idle_cycle(1'b1, 1'b1);

    // Error pulse mid-BUSY, then a clean unread overwrite
    run_sample(16'h00FF, 4, 16'h0008, 16'h0, 16'h0, 1, 1'b0);
    check("t2_err",  32'(bus.result_err), 32'd1);
    check("t2_ovr0", 32'(bus.overrun),    32'd0);
    run_sample(16'h0F0F, 3, 16'h0001, 16'h0, 16'h0, 0, 1'b1);
    check("t2_err_clean", 32'(bus.result_err),  32'd0);
    check("t2_ovr1",      32'(bus.overrun),     32'd1);
    check("t2_data",      32'(bus.result_data), 32'h0F0F);
    idle_cycle(1'b1, 1'b1);

    // Overrun, clear alone, clear colliding with a new overrun
    run_sample(16'hAAAA, 2, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    run_sample(16'h5555, 1, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    check("t3_ovr",  32'(bus.overrun),     32'd1);
    check("t3_data", 32'(bus.result_data), 32'h5555);
    idle_cycle(1'b0, 1'b1);
    check("t3_clr", 32'(bus.overrun), 32'd0);
    run_sample(16'h7777, 2, 16'h0, 16'h0, 16'h0010, 0, 1'b0);
    check("t3_set_wins", 32'(bus.overrun), 32'd1);
    idle_cycle(1'b1, 1'b1);

    // rd_ack on the capture edge, then rd_ack one cycle later
    run_sample(16'h2468, 2, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    run_sample(16'h1357, 2, 16'h0, 16'h0010, 16'h0, 0, 1'b0);
    check("t4_valid_kept", 32'(bus.result_valid), 32'd1);
    check("t4_no_ovr",     32'(bus.overrun),      32'd0);
    idle_cycle(1'b1, 1'b0);
    check("t4_valid_clr", 32'(bus.result_valid), 32'd0);
    check("t4_data_kept", 32'(bus.result_data),  32'h1357);

    // Randomised traffic, long enough to wrap the sample counter
    for (int n = 0; n < 1100; n++) begin
      err_m = '0;
      ack_m = '0;
      clr_m = '0;
      for (int b = 1; b < 16; b++) begin
        err_m[b] = ($urandom_range(0, 7) == 0);
        ack_m[b] = ($urandom_range(0, 3) == 0);
        clr_m[b] = ($urandom_range(0, 5) == 0);
      end
      run_sample(DATA_W'($urandom), int'($urandom_range(1, 5)), err_m, ack_m, clr_m,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted while in CAPTURE
    run_sample(16'hC0DE, 2, 16'h0, 16'h0, 16'h0, 1, 1'b0);
    edge_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    edge_step(1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check("rst_data",  32'(bus.result_data),   32'd0);
    check("rst_valid", 32'(bus.result_valid),  32'd0);
    check("rst_err",   32'(bus.result_err),    32'd0);
    check("rst_ovr",   32'(bus.overrun),       32'd0);
    check("rst_count", 32'(bus.sample_count),  32'd0);
    check("rst_onek",  32'(bus.one_k_samples), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.modwait = 1'b0;
    n_rst       = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) edge_step(1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    check("post_rst_valid", 32'(bus.result_valid), 32'd0);
    check("post_rst_data",  32'(bus.result_data),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule : tb_result_handshake
